// File: rtl/led_pkg.sv
// Shared types and sizes for the LED shift-entry blocks (shifter and pattern player).
package led_pkg;

    localparam int LED_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } player_state_t;

endpackage

// File: rtl/led_gap_timer.sv
// Inter-strobe gap timer: counts while run is high and flags the last cycle of the gap.
module led_gap_timer #(
    parameter int GAP_CYCLES = 25_000_000,
    parameter int CNT_W      = 25
) (
    input  logic clk,
    input  logic async_reset_debounced,
    input  logic clear,
    input  logic run,
    output logic expire
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(GAP_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    assign expire = (cnt == LAST_CNT);

    // Wraps to zero on expiry so the count never passes GAP_CYCLES-1.
    always_ff @(posedge clk or negedge async_reset_debounced) begin
        if (!async_reset_debounced) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= expire ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_pattern_player.sv
// Replays a WIDTH-bit pattern MSB-first as bit_0_re / bit_1_re strobes paced by a gap timer.
// Build option LED_PATTERN_PLAYER_REPEAT_EN: loop the pattern until a start_re stops playback.
//
// state | meaning
// IDLE  | waiting for start_re
// GAP   | gap timer running before the next strobe
// EMIT  | one-cycle strobe of shift_reg MSB
// DONE  | one-cycle done pulse after the last strobe
module led_pattern_player
    import led_pkg::*;
#(
    parameter int WIDTH      = LED_WIDTH,
    parameter int GAP_CYCLES = 25_000_000,
    parameter int CNT_W      = 25
) (
    input  logic             clk,
    input  logic             async_reset_debounced,
    input  logic             start_re,
    input  logic [WIDTH-1:0] pattern_in,
    output logic             bit_0_re,
    output logic             bit_1_re,
    output logic             busy,
    output logic             done
);

    localparam int BCW = $clog2(WIDTH + 1);

    player_state_t    state, state_nxt;
    logic [WIDTH-1:0] shift_reg, shift_nxt;
    logic [BCW-1:0]   bit_cnt, bit_cnt_nxt;
    logic             gap_expire;

    led_gap_timer #(
        .GAP_CYCLES(GAP_CYCLES),
        .CNT_W     (CNT_W)
    ) u_gap_timer (
        .clk                  (clk),
        .async_reset_debounced(async_reset_debounced),
        .clear                (state != GAP),
        .run                  (state == GAP),
        .expire               (gap_expire)
    );

`ifdef LED_PATTERN_PLAYER_REPEAT_EN
    logic [WIDTH-1:0] load_reg;

    always_ff @(posedge clk or negedge async_reset_debounced) begin
        if (!async_reset_debounced) begin
            load_reg <= '0;
        end else if (state == IDLE && start_re) begin
            load_reg <= pattern_in;
        end
    end
`endif

    always_ff @(posedge clk or negedge async_reset_debounced) begin
        if (!async_reset_debounced) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            shift_reg <= shift_nxt;
            bit_cnt   <= bit_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift_reg;
        bit_cnt_nxt = bit_cnt;
        case (state)
            IDLE: begin
                if (start_re) begin
                    shift_nxt   = pattern_in;
                    bit_cnt_nxt = BCW'(WIDTH);
                    state_nxt   = GAP;
                end
            end
            GAP: begin
                if (gap_expire) begin
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                shift_nxt   = shift_reg << 1;
                bit_cnt_nxt = bit_cnt - BCW'(1);
                state_nxt   = (bit_cnt == BCW'(1)) ? DONE : GAP;
            end
            DONE: begin
`ifdef LED_PATTERN_PLAYER_REPEAT_EN
                shift_nxt   = load_reg;
                bit_cnt_nxt = BCW'(WIDTH);
                state_nxt   = GAP;
`else
                state_nxt   = IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase
`ifdef LED_PATTERN_PLAYER_REPEAT_EN
        // In repeat mode a start while playing is the stop request.
        if (state != IDLE && start_re) begin
            state_nxt = IDLE;
        end
`endif
    end

    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign bit_1_re = (state == EMIT) &&  shift_reg[WIDTH-1];
    assign bit_0_re = (state == EMIT) && !shift_reg[WIDTH-1];

endmodule
